// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
//   Shares one variable-latency memory port between instruction fetch and
//   data access. Data wins by default; a bounded data streak lets a waiting
//   fetch through.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  localparam logic [3:0] C_MAX_BURST = 4'(MAX_DATA_BURST);
  localparam logic [3:0] C_STREAK_SAT = 4'hF;

  state_t              r_state;
  logic [3:0]          r_streak;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic                r_if_valid;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_d_valid;
  logic                r_busy;

  logic                w_if_eff;
  logic                w_d_eff;
  logic                w_pick_data;
  logic [3:0]          w_streak_inc;

  // A requester still holding req in its own valid cycle must not be re-granted.
  assign w_if_eff     = if_req & ~r_if_valid;
  assign w_d_eff      = d_req  & ~r_d_valid;
  assign w_pick_data  = w_d_eff & (~w_if_eff | (r_streak < C_MAX_BURST));
  assign w_streak_inc = (r_streak == C_STREAK_SAT) ? r_streak : r_streak + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_streak    <= 4'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_d_rdata   <= '0;
      r_d_valid   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_data) begin
            r_state     <= S_DATA;
            r_busy      <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_streak    <= w_streak_inc;
          end else if (w_if_eff) begin
            r_state     <= S_FETCH;
            r_busy      <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_streak    <= 4'd0;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_if_rdata <= mem_rdata;
            r_if_valid <= 1'b1;
          end
        end
        S_DATA: begin
          if (mem_ack) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            // Stores leave the last load result visible.
            if (!r_mem_we) begin
              r_d_rdata <= mem_rdata;
            end
            r_d_valid <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign d_rdata   = r_d_rdata;
  assign d_valid   = r_d_valid;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// traffic, checked against a transaction-level reference model.
`default_nettype none

module tb_mem_port_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req, d_req, d_we, mem_ack;
  logic [15:0] if_addr, d_addr;
  logic [31:0] d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_wdata;
  logic        if_valid, d_valid, mem_req, mem_we, busy;
  logic [15:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_DATA_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  // environment memory (answers the DUT) and reference memory (predicts results)
  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];

  // reference model: owner 0 = none, 1 = fetch, 2 = data
  int          m_owner, m_streak;
  logic        exp_mem_req, exp_if_valid, exp_d_valid;
  logic [31:0] exp_if_rdata, exp_d_rdata;
  logic [15:0] g_addr;
  logic        g_we;
  logic [31:0] g_wdata;

  logic        if_busy, if_gnt, if_fin, d_busy, d_gnt, d_fin;
  int          if_prob, d_prob, ack_max, env_wait;
  logic        scramble, ack_rand, env_prev;

  int n_assert, n_fail;
  int n_txn, n_req_cyc, n_iv, n_dv, cyc, t_iv, t_dv;
  int glog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic start_if(input logic [15:0] a);
    if_busy = 1'b1; if_req = 1'b1; if_addr = a;
  endtask

  task automatic start_d(input logic we, input logic [15:0] a, input logic [31:0] wd);
    d_busy = 1'b1; d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  task automatic model_clear();
    m_owner = 0; m_streak = 0;
    exp_mem_req = 1'b0; exp_if_valid = 1'b0; exp_d_valid = 1'b0;
    exp_if_rdata = 32'h0; exp_d_rdata = 32'h0;
    g_addr = 16'h0; g_we = 1'b0; g_wdata = 32'h0;
    if_busy = 1'b0; if_gnt = 1'b0; if_fin = 1'b0;
    d_busy = 1'b0; d_gnt = 1'b0; d_fin = 1'b0;
    env_wait = 0; env_prev = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 16'h0; d_addr = 16'h0; d_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
  endtask

  // one clock cycle: drive agents and memory, predict, clock, compare
  task automatic step();
    logic        ie, de, nv_i, nv_d;
    logic [31:0] nr_i, nr_d;
    nv_i = 1'b0; nv_d = 1'b0; nr_i = exp_if_rdata; nr_d = exp_d_rdata;
    if (if_fin) begin if_fin = 1'b0; if_busy = 1'b0; if_gnt = 1'b0; if_req = 1'b0; end
    if (d_fin)  begin d_fin  = 1'b0; d_busy  = 1'b0; d_gnt  = 1'b0; d_req  = 1'b0; end
    if (!if_busy && int'($urandom_range(99)) < if_prob) start_if(16'($urandom));
    if (!d_busy && int'($urandom_range(99)) < d_prob)
      start_d(1'($urandom), 16'($urandom), $urandom);
    if (scramble && if_gnt) begin
      if ($urandom_range(3) == 0) if_addr = 16'($urandom);
      if ($urandom_range(7) == 0) if_req = 1'b0;
    end
    if (scramble && d_gnt) begin
      if ($urandom_range(3) == 0) begin
        d_addr = 16'($urandom); d_wdata = $urandom; d_we = 1'($urandom);
      end
      if ($urandom_range(7) == 0) d_req = 1'b0;
    end
    if (mem_req && !env_prev) begin
      n_txn++;
      env_wait = ack_rand ? int'($urandom_range(32'(ack_max))) : ack_max;
    end
    env_prev = mem_req;
    if (mem_req && env_wait == 0) begin
      mem_ack = 1'b1;
      mem_rdata = env_mem[mem_addr[7:0]];
      if (mem_we) env_mem[mem_addr[7:0]] = mem_wdata;
    end else begin
      if (mem_req) env_wait--;
      mem_ack = !mem_req && ($urandom_range(3) == 0);
      mem_rdata = $urandom;
    end
    if (m_owner != 0) begin
      if (mem_ack) begin
        if (m_owner == 1) begin
          nv_i = 1'b1; nr_i = ref_mem[g_addr[7:0]];
        end else begin
          nv_d = 1'b1;
          if (g_we) ref_mem[g_addr[7:0]] = g_wdata;
          else nr_d = ref_mem[g_addr[7:0]];
        end
        m_owner = 0;
      end
    end else begin
      ie = if_req && !exp_if_valid;
      de = d_req && !exp_d_valid;
      if (de && (!ie || m_streak < MAXB)) begin
        m_owner = 2; g_addr = d_addr; g_we = d_we; g_wdata = d_wdata;
        m_streak = (m_streak < 15) ? m_streak + 1 : 15;
        d_gnt = 1'b1; glog.push_back(2);
      end else if (ie) begin
        m_owner = 1; g_addr = if_addr; g_we = 1'b0; m_streak = 0;
        if_gnt = 1'b1; glog.push_back(1);
      end
    end
    if (exp_if_valid) if_fin = 1'b1;
    if (exp_d_valid)  d_fin  = 1'b1;
    @(posedge clk); #1;
    cyc++;
    exp_if_valid = nv_i; exp_d_valid = nv_d;
    exp_if_rdata = nr_i; exp_d_rdata = nr_d;
    exp_mem_req = (m_owner != 0);
    if (mem_req) n_req_cyc++;
    if (if_valid) begin n_iv++; t_iv = cyc; end
    if (d_valid)  begin n_dv++; t_dv = cyc; end
    chk("mem_req", {31'd0, mem_req}, {31'd0, exp_mem_req});
    chk("busy", {31'd0, busy}, {31'd0, exp_mem_req});
    chk("if_valid", {31'd0, if_valid}, {31'd0, exp_if_valid});
    chk("d_valid", {31'd0, d_valid}, {31'd0, exp_d_valid});
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
    chk("mem_we", {31'd0, mem_we}, {31'd0, exp_mem_req & g_we});
    if (exp_mem_req) begin
      chk("mem_addr", {16'd0, mem_addr}, {16'd0, g_addr});
      if (m_owner == 2) chk("mem_wdata", mem_wdata, g_wdata);
    end
  endtask

  task automatic run_quiet(input int extra);
    int b;
    b = 0;
    while ((if_busy || d_busy || m_owner != 0) && b < 200) begin
      step();
      b++;
    end
    chk("drain", 32'(int'(if_busy) + int'(d_busy) + m_owner), 32'd0);
    repeat (extra) step();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] v;
    n_assert = 0; n_fail = 0; cyc = 0;
    n_txn = 0; n_req_cyc = 0; n_iv = 0; n_dv = 0; t_iv = 0; t_dv = 0;
    if_prob = 0; d_prob = 0; scramble = 1'b0; ack_rand = 1'b0; ack_max = 0;
    model_clear();
    for (int i = 0; i < 256; i++) begin
      v = $urandom; env_mem[i] = v; ref_mem[i] = v;
    end
    env_mem[8'h10] = 32'h00500093; ref_mem[8'h10] = 32'h00500093;
    do_reset();

    // single fetch, zero wait states
    start_if(16'h0010);
    step();
    chk("fetch_addr", {16'd0, mem_addr}, 32'h0010);
    chk("fetch_we", {31'd0, mem_we}, 32'd0);
    step();
    chk("fetch_valid", {31'd0, if_valid}, 32'd1);
    chk("fetch_rdata", if_rdata, 32'h00500093);
    run_quiet(1);

    // store with three wait states
    ack_max = 3; n_req_cyc = 0; n_dv = 0;
    start_d(1'b1, 16'h0200, 32'hDEADBEEF);
    step();
    chk("store_wdata", mem_wdata, 32'hDEADBEEF);
    chk("store_we", {31'd0, mem_we}, 32'd1);
    run_quiet(1);
    chk("store_req_cycles", 32'(n_req_cyc), 32'd4);
    chk("store_dvalid_count", 32'(n_dv), 32'd1);
    chk("store_rdata_kept", d_rdata, 32'd0);

    // simultaneous requests: data first, then fetch
    ack_max = 0; n_iv = 0; n_dv = 0;
    start_if(16'h0040);
    start_d(1'b0, 16'h0300, 32'h0);
    run_quiet(1);
    chk("sim_if_count", 32'(n_iv), 32'd1);
    chk("sim_d_count", 32'(n_dv), 32'd1);
    chk("sim_order", {31'd0, t_dv < t_iv}, 32'd1);

    // streak at the limit: four data-only grants, then a tie goes to fetch
    for (int k = 0; k < 4; k++) begin
      start_d(1'b0, 16'(k * 4), 32'h0);
      run_quiet(1);
    end
    glog.delete();
    start_if(16'h0044);
    start_d(1'b0, 16'h0048, 32'h0);
    run_quiet(1);
    chk("streak_at_limit_first", 32'(glog[0]), 32'd1);
    chk("streak_at_limit_second", 32'(glog[1]), 32'd2);

    // streak below the limit: a tie still goes to data
    for (int k = 0; k < 2; k++) begin
      start_d(1'b1, 16'(8 + k), $urandom);
      run_quiet(1);
    end
    glog.delete();
    start_if(16'h0050);
    start_d(1'b0, 16'h0054, 32'h0);
    run_quiet(1);
    chk("streak_below_first", 32'(glog[0]), 32'd2);
    chk("streak_below_second", 32'(glog[1]), 32'd1);

    // req held through valid cycle yields a single transaction
    n_txn = 0;
    start_if(16'h0020);
    run_quiet(3);
    chk("dup_txn", 32'(n_txn), 32'd1);

    // reset in the middle of a data transaction
    ack_max = 5;
    start_d(1'b1, 16'h0300, 32'h12345678);
    step();
    step();
    chk("pre_reset_req", {31'd0, mem_req}, 32'd1);
    do_reset();
    n_iv = 0; n_dv = 0; n_txn = 0;
    repeat (5) step();
    chk("post_reset_if", 32'(n_iv), 32'd0);
    chk("post_reset_d", 32'(n_dv), 32'd0);
    chk("post_reset_txn", 32'(n_txn), 32'd0);

    // randomized traffic, including saturated contention phases
    scramble = 1'b1; ack_rand = 1'b1; ack_max = 3;
    for (int p = 0; p < 16; p++) begin
      if (p % 4 == 0) begin
        if_prob = 100; d_prob = 100;
      end else begin
        if_prob = int'($urandom_range(90, 10));
        d_prob  = int'($urandom_range(90, 10));
      end
      repeat (100) step();
    end
    if_prob = 0; d_prob = 0;
    run_quiet(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the core's instruction-fetch port and its data (load/store) port.
- Sits between the rv32i core and unified program/data memory. Serialises requests with fixed data-over-fetch priority plus an anti-starvation limit.
- Registers every request and returns a one-cycle valid pulse to the requester when the memory acknowledges.

Parameters:
- ADDR_W, 16, address width, matching the core's pc/address ports.
- DATA_W, 32, data word width.
- MAX_DATA_BURST, 4, max consecutive data grants while a fetch is pending; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; registered.
- if_valid  out  1  one-cycle pulse: if_rdata is valid.
- d_req  in  1  data request; held until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; registered.
- d_valid  out  1  one-cycle pulse: data access complete.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack=1.
- mem_ack  in  1  memory completion; sampled only while mem_req=1.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; mem_req, mem_we, if_valid, d_valid, busy = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; streak counter = 0.
- Reset during a memory transaction abandons it. mem_req drops without waiting for mem_ack, and no valid pulse is produced.
- States: IDLE, FETCH, DATA.
- Effective requests, evaluated in IDLE:
  - if_eff = if_req & ~if_valid
  - d_eff = d_req & ~d_valid
  - Masking the req in its own valid cycle prevents a duplicate grant.
- Arbitration in IDLE:
  - d_eff & (~if_eff | streak < MAX_DATA_BURST) → DATA; streak increments, saturating at 15.
  - else if_eff → FETCH; streak = 0.
  - else stay in IDLE.
- On a grant edge:
  - mem_addr, mem_we (d_we for DATA, 0 for FETCH) and mem_wdata are latched from the winning requester.
  - mem_req = 1 from the next cycle, which is the first cycle in FETCH/DATA.
  - Requester inputs are ignored until completion.
- In FETCH/DATA:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable.
  - On a rising edge with mem_ack=1: state → IDLE; mem_req = 0 and mem_we = 0.
  - FETCH completion: if_rdata ← mem_rdata.
  - DATA load completion: d_rdata ← mem_rdata.
  - DATA store completion: d_rdata keeps its previous value.
  - The matching valid is high for exactly the following cycle.
- Latency:
  - Minimum request-to-valid is 3 cycles: grant edge, mem_req cycle with mem_ack=1, valid cycle.
  - Each extra cycle of mem_ack=0 adds one cycle.
- A requester dropping req mid-transaction does not cancel it; the transaction completes and valid still pulses.
- Back-to-back: a new grant may be taken in the same IDLE cycle in which the other requester's valid is high.
- streak counts data grants since the last fetch grant. Data grants with no fetch pending also increment it.
- busy is a registered decode of state.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0010; memory acks in its first mem_req cycle with 0x00500093 → mem_addr=0x0010, mem_we=0; if_valid pulses 3 cycles after if_req with if_rdata=0x00500093.
- Store with wait states: d_req=1, d_we=1, d_addr=0x0200, d_wdata=0xDEADBEEF, mem_ack delayed 3 cycles → mem_req held 4 cycles with constant addr/data; d_valid pulses once; d_rdata unchanged.
- Simultaneous requests: if_req and d_req (load 0x0300) in the same cycle → DATA first, then FETCH; d_valid precedes if_valid; exactly one valid per request.
- Starvation guard, MAX_DATA_BURST=4: d_req and if_req held continuously, d_req re-raised after every d_valid → exactly 4 data grants, then 1 fetch grant, then data resumes.
- Reset mid-transaction: rst_n=0 while in DATA with mem_req=1 → mem_req, busy and valids 0 immediately. After release with no requests, state stays IDLE and no valid pulses.
- Duplicate-grant check: requester holds req through its valid cycle and drops it one cycle later → only one memory transaction is issued.
